// File: rtl/tcm_dual_port_mem.sv
// Tightly-coupled 128 KB memory: 64-bit instruction fetch port plus a 32-bit
// byte-masked data port, both answering exactly one cycle after the request.

module tcm_dual_port_mem_ram #(
    parameter int ADDR_W = 14
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    // port a: fetch, read-only
    input  logic              i_a_rd,
    input  logic [ADDR_W-1:0] i_a_idx,
    output logic [63:0]       o_a_data,
    // port b: data, read-first with per-byte write enables
    input  logic              i_b_rd,
    input  logic [ADDR_W-1:0] i_b_idx,
    input  logic [7:0]        i_b_be,
    input  logic [63:0]       i_b_wdata,
    output logic [63:0]       o_b_data
);

    logic [63:0] ram [0:(1<<ADDR_W)-1];
    logic [63:0] r_a_data;
    logic [63:0] r_b_data;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_a_data <= '0;
        end else if (i_a_rd) begin
            r_a_data <= ram[i_a_idx];
        end
    end

    // Reads sample the pre-edge contents, so a same-cycle write on port b is
    // invisible to both ports until the following access.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_b_data <= '0;
        end else if (i_b_rd) begin
            r_b_data <= ram[i_b_idx];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            for (int b = 0; b < 8; b++) begin
                if (i_b_be[b]) begin
                    ram[i_b_idx][b*8 +: 8] <= i_b_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign o_a_data = r_a_data;
    assign o_b_data = r_b_data;

    // Image preload: sets one byte regardless of clock or reset.
    task automatic write(input logic [ADDR_W+2:0] addr, input logic [7:0] data);
        ram[addr[ADDR_W+2:3]][{addr[2:0], 3'b000} +: 8] <= data;
    endtask

endmodule

module tcm_dual_port_mem #(
    parameter int RAM_ADDR_W = 14
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_i_rd_i,
    input  logic        mem_i_flush_i,
    input  logic        mem_i_invalidate_i,
    input  logic [31:0] mem_i_pc_i,
    output logic        mem_i_accept_o,
    output logic        mem_i_valid_o,
    output logic        mem_i_error_o,
    output logic [63:0] mem_i_inst_o,
    input  logic [31:0] mem_d_addr_i,
    input  logic [31:0] mem_d_data_wr_i,
    input  logic        mem_d_rd_i,
    input  logic [3:0]  mem_d_wr_i,
    input  logic        mem_d_cacheable_i,
    input  logic [10:0] mem_d_req_tag_i,
    input  logic        mem_d_invalidate_i,
    input  logic        mem_d_writeback_i,
    input  logic        mem_d_flush_i,
    output logic [31:0] mem_d_data_rd_o,
    output logic        mem_d_accept_o,
    output logic        mem_d_ack_o,
    output logic        mem_d_error_o,
    output logic [10:0] mem_d_resp_tag_o
);

    // Handshake: accept is tied high, so a request is taken whenever it is
    // presented; its response (valid/ack) is a one-cycle pulse in the next cycle.

    logic [RAM_ADDR_W-1:0] w_i_idx;
    logic [RAM_ADDR_W-1:0] w_d_idx;
    logic                  w_d_req;
    logic [7:0]            w_d_be;
    logic [63:0]           w_d_wdata;
    logic [63:0]           w_a_data;
    logic [63:0]           w_b_data;
    logic                  w_unused;

    logic                  r_i_valid;
    logic                  r_d_ack;
    logic [10:0]           r_d_tag;
    logic                  r_d_lane;

    assign w_i_idx   = mem_i_pc_i[RAM_ADDR_W+2:3];
    assign w_d_idx   = mem_d_addr_i[RAM_ADDR_W+2:3];
    assign w_d_req   = mem_d_rd_i | (|mem_d_wr_i) | mem_d_invalidate_i
                     | mem_d_writeback_i | mem_d_flush_i;
    assign w_d_be    = mem_d_addr_i[2] ? {mem_d_wr_i, 4'b0000} : {4'b0000, mem_d_wr_i};
    assign w_d_wdata = {mem_d_data_wr_i, mem_d_data_wr_i};

    tcm_dual_port_mem_ram #(
        .ADDR_W (RAM_ADDR_W)
    ) u_ram (
        .i_clk     (clk_i),
        .i_rst_n   (rst_i),
        .i_a_rd    (mem_i_rd_i),
        .i_a_idx   (w_i_idx),
        .o_a_data  (w_a_data),
        .i_b_rd    (mem_d_rd_i),
        .i_b_idx   (w_d_idx),
        .i_b_be    (w_d_be),
        .i_b_wdata (w_d_wdata),
        .o_b_data  (w_b_data)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_i_valid <= 1'b0;
            r_d_ack   <= 1'b0;
            r_d_tag   <= '0;
            r_d_lane  <= 1'b0;
        end else begin
            r_i_valid <= mem_i_rd_i;
            r_d_ack   <= w_d_req;
            if (w_d_req) begin
                r_d_tag <= mem_d_req_tag_i;
            end
            if (mem_d_rd_i) begin
                r_d_lane <= mem_d_addr_i[2];
            end
        end
    end

    assign mem_i_accept_o   = 1'b1;
    assign mem_i_valid_o    = r_i_valid;
    assign mem_i_error_o    = 1'b0;
    assign mem_i_inst_o     = w_a_data;
    assign mem_d_accept_o   = 1'b1;
    assign mem_d_ack_o      = r_d_ack;
    assign mem_d_error_o    = 1'b0;
    assign mem_d_resp_tag_o = r_d_tag;
    assign mem_d_data_rd_o  = r_d_lane ? w_b_data[63:32] : w_b_data[31:0];

    // Fetch-side maintenance, cacheability and out-of-range address bits have no effect.
    assign w_unused = &{1'b0, mem_i_flush_i, mem_i_invalidate_i, mem_d_cacheable_i,
                        mem_i_pc_i[31:RAM_ADDR_W+3], mem_i_pc_i[2:0],
                        mem_d_addr_i[31:RAM_ADDR_W+3], mem_d_addr_i[1:0]};

endmodule

// File: tb/tb_tcm_dual_port_mem.sv
// Self-checking bench for tcm_dual_port_mem: a byte-accurate memory model feeds
// per-port expected queues that are drained as responses appear.

module tb_tcm_dual_port_mem;

    localparam int AW = 14;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        mem_i_rd_i;
    logic        mem_i_flush_i;
    logic        mem_i_invalidate_i;
    logic [31:0] mem_i_pc_i;
    logic        mem_i_accept_o;
    logic        mem_i_valid_o;
    logic        mem_i_error_o;
    logic [63:0] mem_i_inst_o;
    logic [31:0] mem_d_addr_i;
    logic [31:0] mem_d_data_wr_i;
    logic        mem_d_rd_i;
    logic [3:0]  mem_d_wr_i;
    logic        mem_d_cacheable_i;
    logic [10:0] mem_d_req_tag_i;
    logic        mem_d_invalidate_i;
    logic        mem_d_writeback_i;
    logic        mem_d_flush_i;
    logic [31:0] mem_d_data_rd_o;
    logic        mem_d_accept_o;
    logic        mem_d_ack_o;
    logic        mem_d_error_o;
    logic [10:0] mem_d_resp_tag_o;

    int checks = 0;
    int errors = 0;

    // data entry: {tag[10:0], check_data, data[31:0]}
    logic [43:0] d_exp_q[$];
    logic [63:0] i_exp_q[$];
    logic [63:0] model [logic [AW-1:0]];

    always #5 clk_i = ~clk_i;

    tcm_dual_port_mem #(.RAM_ADDR_W(AW)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .mem_i_rd_i         (mem_i_rd_i),
        .mem_i_flush_i      (mem_i_flush_i),
        .mem_i_invalidate_i (mem_i_invalidate_i),
        .mem_i_pc_i         (mem_i_pc_i),
        .mem_i_accept_o     (mem_i_accept_o),
        .mem_i_valid_o      (mem_i_valid_o),
        .mem_i_error_o      (mem_i_error_o),
        .mem_i_inst_o       (mem_i_inst_o),
        .mem_d_addr_i       (mem_d_addr_i),
        .mem_d_data_wr_i    (mem_d_data_wr_i),
        .mem_d_rd_i         (mem_d_rd_i),
        .mem_d_wr_i         (mem_d_wr_i),
        .mem_d_cacheable_i  (mem_d_cacheable_i),
        .mem_d_req_tag_i    (mem_d_req_tag_i),
        .mem_d_invalidate_i (mem_d_invalidate_i),
        .mem_d_writeback_i  (mem_d_writeback_i),
        .mem_d_flush_i      (mem_d_flush_i),
        .mem_d_data_rd_o    (mem_d_data_rd_o),
        .mem_d_accept_o     (mem_d_accept_o),
        .mem_d_ack_o        (mem_d_ack_o),
        .mem_d_error_o      (mem_d_error_o),
        .mem_d_resp_tag_o   (mem_d_resp_tag_o)
    );

    function automatic logic [63:0] model_get(input logic [AW-1:0] idx);
        if (model.exists(idx)) return model[idx];
        return 64'h0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        mem_i_rd_i = 1'b0; mem_i_flush_i = 1'b0; mem_i_invalidate_i = 1'b0;
        mem_i_pc_i = '0; mem_d_addr_i = '0; mem_d_data_wr_i = '0;
        mem_d_rd_i = 1'b0; mem_d_wr_i = '0; mem_d_cacheable_i = 1'b0;
        mem_d_req_tag_i = '0; mem_d_invalidate_i = 1'b0;
        mem_d_writeback_i = 1'b0; mem_d_flush_i = 1'b0;
    endtask

    task automatic bd_write(input logic [AW+2:0] a, input logic [7:0] b);
        logic [63:0] w;
        dut.u_ram.write(a, b);
        w = model_get(a[AW+2:3]);
        w[{a[2:0], 3'b000} +: 8] = b;
        model[a[AW+2:3]] = w;
    endtask

    // Must be called before drive_d in a cycle so fetches see pre-write data.
    task automatic drive_i(input logic rd, input logic [31:0] pc);
        mem_i_rd_i = rd;
        mem_i_pc_i = pc;
        mem_i_flush_i = ~rd;
        mem_i_invalidate_i = ~rd;
        if (rst_i && rd) i_exp_q.push_back(model_get(pc[AW+2:3]));
    endtask

    task automatic drive_d(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [10:0] tag,
                           input logic [2:0] maint);
        logic [63:0]   word;
        logic [AW-1:0] idx;
        logic [31:0]   lane_val;
        mem_d_rd_i = rd; mem_d_wr_i = wr; mem_d_addr_i = addr;
        mem_d_data_wr_i = wdata; mem_d_req_tag_i = tag;
        mem_d_invalidate_i = maint[2]; mem_d_writeback_i = maint[1]; mem_d_flush_i = maint[0];
        mem_d_cacheable_i = $urandom_range(0, 1) == 1;
        if (rst_i && (rd || wr != 4'h0 || maint != 3'b000)) begin
            idx = addr[AW+2:3];
            word = model_get(idx);
            lane_val = addr[2] ? word[63:32] : word[31:0];
            d_exp_q.push_back({tag, rd, lane_val});
            for (int b = 0; b < 4; b++) begin
                if (wr[b]) word[{addr[2], b[1:0], 3'b000} +: 8] = wdata[b*8 +: 8];
            end
            model[idx] = word;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_i = 1'b0;
        idle_inputs();
        @(negedge clk_i);
        drive_i(1'b1, 32'h8000_0000);
        drive_d(1'b1, 4'hF, 32'h8000_0000, 32'hFFFF_FFFF, 11'h7AA, 3'b000);
        @(negedge clk_i);
        checks++; if (mem_i_accept_o !== 1'b1) begin errors++; $display("FAIL reset_i_accept got=%b want=1", mem_i_accept_o); end
        checks++; if (mem_d_accept_o !== 1'b1) begin errors++; $display("FAIL reset_d_accept got=%b want=1", mem_d_accept_o); end
        checks++; if (mem_i_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", mem_i_valid_o); end
        checks++; if (mem_d_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b want=0", mem_d_ack_o); end
        checks++; if (mem_d_resp_tag_o !== 11'h0) begin errors++; $display("FAIL reset_tag got=%h want=0", mem_d_resp_tag_o); end
        checks++; if (mem_i_inst_o !== 64'h0) begin errors++; $display("FAIL reset_inst got=%h want=0", mem_i_inst_o); end
        checks++; if (mem_d_data_rd_o !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h want=0", mem_d_data_rd_o); end
        checks++; if (mem_i_error_o !== 1'b0 || mem_d_error_o !== 1'b0) begin
            errors++; $display("FAIL reset_error got=%b%b want=00", mem_i_error_o, mem_d_error_o); end
        idle_inputs();
        rst_i = 1'b1;
    endtask

    task automatic test_preload_fetch();
        logic [7:0]  img [8];
        logic [63:0] e;
        img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        for (int k = 0; k < 8; k++) bd_write(17'(k), img[k]);
        for (int k = 0; k < 64; k++) bd_write(17'(32'h9000 + k), 8'($urandom_range(0, 255)));
        #1;
        checks++; if (dut.u_ram.ram[0] !== 64'h0010_0093_0000_0013) begin
            errors++; $display("FAIL backdoor_word got=%h want=0010009300000013", dut.u_ram.ram[0]); end
        @(negedge clk_i);
        drive_i(1'b1, 32'h8000_0000);
        @(negedge clk_i);
        e = i_exp_q.pop_front();
        checks++; if (mem_i_valid_o !== 1'b1 || mem_i_inst_o !== e) begin
            errors++; $display("FAIL fetch_alias valid=%b inst=%h want 1/%h", mem_i_valid_o, mem_i_inst_o, e); end
        idle_inputs();
        @(negedge clk_i);
        checks++; if (mem_i_valid_o !== 1'b0) begin errors++; $display("FAIL fetch_pulse got=%b want=0", mem_i_valid_o); end
    endtask

    task automatic test_store();
        logic [31:0] hi_before;
        logic [43:0] e;
        hi_before = model_get(14'h1200) >> 32;
        @(negedge clk_i);
        drive_d(1'b0, 4'hF, 32'h8000_9000, 32'hFFFF_0000, 11'h155, 3'b000);
        @(negedge clk_i);
        e = d_exp_q.pop_front();
        checks++; if (mem_d_ack_o !== 1'b1 || mem_d_resp_tag_o !== 11'h155) begin
            errors++; $display("FAIL store_ack ack=%b tag=%h want 1/155", mem_d_ack_o, mem_d_resp_tag_o); end
        checks++; if (dut.u_ram.ram[14'h1200] !== {hi_before, 32'hFFFF_0000}) begin
            errors++; $display("FAIL store_word got=%h want=%h", dut.u_ram.ram[14'h1200], {hi_before, 32'hFFFF_0000}); end
        idle_inputs();
        if (e[43:33] !== 11'h155) $display("note: queue tag %h", e[43:33]);
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        logic [43:0] e;
        vals = '{32'h1111_0000, 32'hAAAA_0000, 32'hFFFF_0000, 32'hC0FF_EE00};
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk_i);
            if (k > 0) begin
                checks++;
                if (d_exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_queue step=%0d empty", k);
                end else begin
                    e = d_exp_q.pop_front();
                    if (mem_d_ack_o !== 1'b1 || mem_d_resp_tag_o !== e[43:33]) begin
                        errors++; $display("FAIL b2b_ack step=%0d ack=%b tag=%h want 1/%h", k, mem_d_ack_o, mem_d_resp_tag_o, e[43:33]); end
                    if (e[32]) begin
                        checks++; if (mem_d_data_rd_o !== vals[k-5]) begin
                            errors++; $display("FAIL b2b_read step=%0d got=%h want=%h", k, mem_d_data_rd_o, vals[k-5]); end
                    end
                end
            end
            idle_inputs();
            if (k < 4) drive_d(1'b0, 4'hF, 32'h8000_9008 + 32'(k*8), vals[k], 11'(k + 1), 3'b000);
            else if (k < 8) drive_d(1'b1, 4'h0, 32'h8000_9008 + 32'((k-4)*8), 32'h0, 11'(k + 16), 3'b000);
        end
        for (int k = 0; k < 4; k++) begin
            checks++; if (dut.u_ram.ram[14'h1201 + 14'(k)][31:0] !== vals[k]) begin
                errors++; $display("FAIL b2b_ram idx=%0d got=%h want=%h", k, dut.u_ram.ram[14'h1201 + 14'(k)][31:0], vals[k]); end
        end
    endtask

    task automatic test_byte_write();
        logic [43:0] e;
        @(negedge clk_i);
        drive_d(1'b0, 4'hF, 32'h8000_9004, 32'h1234_5678, 11'h001, 3'b000);
        @(negedge clk_i);
        e = d_exp_q.pop_front();
        drive_d(1'b0, 4'h2, 32'h8000_9004, 32'h0000_AB00, 11'h002, 3'b000);
        @(negedge clk_i);
        e = d_exp_q.pop_front();
        checks++; if (mem_d_ack_o !== 1'b1 || mem_d_resp_tag_o !== 11'h002) begin
            errors++; $display("FAIL bytew_ack ack=%b tag=%h want 1/002", mem_d_ack_o, mem_d_resp_tag_o); end
        drive_d(1'b1, 4'h0, 32'h8000_9004, 32'h0, 11'h003, 3'b000);
        @(negedge clk_i);
        e = d_exp_q.pop_front();
        checks++; if (mem_d_data_rd_o !== 32'h1234_AB78) begin
            errors++; $display("FAIL bytew_read got=%h want=1234ab78", mem_d_data_rd_o); end
        checks++; if (dut.u_ram.ram[14'h1200][31:0] !== 32'hFFFF_0000) begin
            errors++; $display("FAIL bytew_other_lane got=%h want=ffff0000", dut.u_ram.ram[14'h1200][31:0]); end
        idle_inputs();
    endtask

    task automatic test_read_during_write();
        logic [43:0] e;
        @(negedge clk_i);
        drive_d(1'b1, 4'hF, 32'h8000_9010, 32'h5A5A_5A5A, 11'h3C3, 3'b000);
        @(negedge clk_i);
        e = d_exp_q.pop_front();
        checks++; if (mem_d_ack_o !== 1'b1 || mem_d_data_rd_o !== e[31:0]) begin
            errors++; $display("FAIL rdw_old ack=%b data=%h want 1/%h", mem_d_ack_o, mem_d_data_rd_o, e[31:0]); end
        drive_d(1'b1, 4'h0, 32'h8000_9010, 32'h0, 11'h3C4, 3'b000);
        @(negedge clk_i);
        e = d_exp_q.pop_front();
        checks++; if (mem_d_data_rd_o !== 32'h5A5A_5A5A) begin
            errors++; $display("FAIL rdw_new got=%h want=5a5a5a5a", mem_d_data_rd_o); end
        idle_inputs();
    endtask

    task automatic test_collision();
        logic [63:0] ei;
        logic [43:0] ed;
        @(negedge clk_i);
        drive_i(1'b1, 32'h8000_9018);
        drive_d(1'b0, 4'hF, 32'h8000_901C, 32'hBEEF_CAFE, 11'h600, 3'b000);
        @(negedge clk_i);
        ei = i_exp_q.pop_front();
        ed = d_exp_q.pop_front();
        checks++; if (mem_i_valid_o !== 1'b1 || mem_i_inst_o !== ei) begin
            errors++; $display("FAIL coll_old valid=%b inst=%h want 1/%h", mem_i_valid_o, mem_i_inst_o, ei); end
        checks++; if (mem_d_ack_o !== 1'b1 || mem_d_resp_tag_o !== ed[43:33]) begin
            errors++; $display("FAIL coll_ack ack=%b tag=%h want 1/%h", mem_d_ack_o, mem_d_resp_tag_o, ed[43:33]); end
        idle_inputs();
        drive_i(1'b1, 32'h8000_9018);
        @(negedge clk_i);
        ei = i_exp_q.pop_front();
        checks++; if (mem_i_inst_o[63:32] !== 32'hBEEF_CAFE || mem_i_inst_o !== ei) begin
            errors++; $display("FAIL coll_new inst=%h want=%h", mem_i_inst_o, ei); end
        idle_inputs();
    endtask

    task automatic test_maintenance();
        logic [43:0] e;
        logic [2:0]  ops [3];
        ops = '{3'b001, 3'b010, 3'b100};
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk_i);
            if (k > 0) begin
                e = d_exp_q.pop_front();
                checks++; if (mem_d_ack_o !== 1'b1 || mem_d_resp_tag_o !== e[43:33]) begin
                    errors++; $display("FAIL maint_ack op=%0d ack=%b tag=%h want 1/%h", k, mem_d_ack_o, mem_d_resp_tag_o, e[43:33]); end
                checks++; if (mem_i_valid_o !== 1'b0) begin
                    errors++; $display("FAIL fetch_maint_valid op=%0d got=%b want=0", k, mem_i_valid_o); end
            end
            idle_inputs();
            if (k < 3) begin
                drive_i(1'b0, 32'h8000_9000);
                drive_d(1'b0, 4'h0, 32'h8000_9000, 32'hDEAD_BEEF, 11'h700 + 11'(k), ops[k]);
            end
        end
        checks++; if (dut.u_ram.ram[14'h1200] !== model_get(14'h1200)) begin
            errors++; $display("FAIL maint_nochange got=%h want=%h", dut.u_ram.ram[14'h1200], model_get(14'h1200)); end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [63:0] ei;
        logic [43:0] ed;
        int op;
        for (int k = 0; k <= 60; k++) begin
            @(negedge clk_i);
            if (k > 0) begin
                checks++;
                if (i_exp_q.size() != 0) begin
                    ei = i_exp_q.pop_front();
                    if (mem_i_valid_o !== 1'b1 || mem_i_inst_o !== ei) begin
                        errors++; $display("FAIL rand_fetch cyc=%0d valid=%b inst=%h want 1/%h", k, mem_i_valid_o, mem_i_inst_o, ei); end
                end else if (mem_i_valid_o !== 1'b0) begin
                    errors++; $display("FAIL rand_fetch_idle cyc=%0d valid=%b want 0", k, mem_i_valid_o);
                end
                checks++;
                if (d_exp_q.size() != 0) begin
                    ed = d_exp_q.pop_front();
                    if (mem_d_ack_o !== 1'b1 || mem_d_resp_tag_o !== ed[43:33] ||
                        (ed[32] && mem_d_data_rd_o !== ed[31:0])) begin
                        errors++; $display("FAIL rand_data cyc=%0d ack=%b tag=%h data=%h want 1/%h/%h", k, mem_d_ack_o, mem_d_resp_tag_o, mem_d_data_rd_o, ed[43:33], ed[31:0]); end
                end else if (mem_d_ack_o !== 1'b0) begin
                    errors++; $display("FAIL rand_data_idle cyc=%0d ack=%b want 0", k, mem_d_ack_o);
                end
            end
            idle_inputs();
            if (k < 60) begin
                drive_i($urandom_range(0, 1) == 1, 32'h8000_9000 + 32'($urandom_range(0, 63)));
                op = $urandom_range(0, 4);
                drive_d(op == 0 || op == 2, (op == 1 || op == 2) ? 4'($urandom_range(0, 15)) : 4'h0,
                        32'h8000_9000 + 32'($urandom_range(0, 63)), $urandom,
                        11'($urandom_range(0, 2047)), op == 3 ? 3'($urandom_range(1, 7)) : 3'b000);
            end
        end
    endtask

    task automatic test_reset_inflight();
        logic [43:0] e;
        logic [63:0] keep;
        @(negedge clk_i);
        drive_d(1'b1, 4'h0, 32'h8000_9008, 32'h0, 11'h7FF, 3'b000);
        @(negedge clk_i);
        e = d_exp_q.pop_front();
        checks++; if (mem_d_ack_o !== 1'b1 || mem_d_resp_tag_o !== 11'h7FF) begin
            errors++; $display("FAIL pre_reset_ack ack=%b tag=%h want 1/7ff", mem_d_ack_o, mem_d_resp_tag_o); end
        keep = model_get(14'h1201);
        rst_i = 1'b0;
        drive_i(1'b1, 32'h8000_9008);
        drive_d(1'b1, 4'hF, 32'h8000_9008, 32'h0BAD_0BAD, 11'h2AA, 3'b000);
        @(negedge clk_i);
        checks++; if (mem_d_ack_o !== 1'b0 || mem_d_resp_tag_o !== 11'h0) begin
            errors++; $display("FAIL inflight_drop ack=%b tag=%h want 0/000", mem_d_ack_o, mem_d_resp_tag_o); end
        checks++; if (mem_i_valid_o !== 1'b0 || mem_d_data_rd_o !== 32'h0 || mem_i_inst_o !== 64'h0) begin
            errors++; $display("FAIL inflight_outputs valid=%b rdata=%h inst=%h want 0", mem_i_valid_o, mem_d_data_rd_o, mem_i_inst_o); end
        checks++; if (dut.u_ram.ram[14'h1201] !== keep) begin
            errors++; $display("FAIL reset_retain got=%h want=%h", dut.u_ram.ram[14'h1201], keep); end
        idle_inputs();
        rst_i = 1'b1;
        drive_d(1'b1, 4'h0, 32'h8000_9008, 32'h0, 11'h0AB, 3'b000);
        @(negedge clk_i);
        e = d_exp_q.pop_front();
        checks++; if (mem_d_ack_o !== 1'b1 || mem_d_data_rd_o !== keep[31:0]) begin
            errors++; $display("FAIL post_reset_read ack=%b data=%h want 1/%h", mem_d_ack_o, mem_d_data_rd_o, keep[31:0]); end
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_preload_fetch();
        test_store();
        test_back_to_back();
        test_byte_write();
        test_read_during_write();
        test_collision();
        test_maintenance();
        test_random();
        test_reset_inflight();
        @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
